// File: rtl/uart_tx_fifo_if.sv
// Host-side transmit port of uart_tx_fifo: write strobe and data in,
// FIFO status, frame-done/overflow pulses and the serial line out.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                 tx_ctrl;
    logic [DATA_BITS-1:0] data_send;
    logic                 transmit_ready;
    logic                 success;
    logic                 tx_dout;
    logic                 busy;
    logic                 overflow;
    logic [CNT_W-1:0]     fifo_count;

    modport master (
        output tx_ctrl, data_send,
        input  transmit_ready, success, tx_dout, busy, overflow, fifo_count
    );

    modport slave (
        input  tx_ctrl, data_send,
        output transmit_ready, success, tx_dout, busy, overflow, fifo_count
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a transmit FIFO; frames are sent
// back-to-back with no idle gap while words remain buffered.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input logic            clk,
    input logic            rst,
    uart_tx_fifo_if.slave  bus
);
    localparam int  CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int  AW         = $clog2(FIFO_DEPTH);
    localparam int  CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int  IW         = 4;
    localparam bit  HAS_PARITY = (PARITY != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 success_q;

    logic                 full, empty, bit_end, last_stop, push, pop, par_bit;
    logic [DATA_BITS-1:0] head;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign bit_end   = (cnt_q == CNT_LAST);
    assign last_stop = (state_q == S_STOP) && bit_end && (idx_q == IW'(STOP_BITS - 1));
    // A pop never frees a slot for a same-cycle push: full uses the current count.
    assign push      = bus.tx_ctrl && !full;
    assign pop       = !empty && ((state_q == S_IDLE) || last_stop);
    assign head      = mem_q[rd_ptr_q];
    assign par_bit   = (PARITY == 2) ? ~(^head) : (^head);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= bus.data_send;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            success_q <= 1'b0;
        end else begin
            success_q <= 1'b0;
            if (state_q != S_IDLE)
                cnt_q <= bit_end ? '0 : cnt_q + CW'(1);

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        shift_q <= head;
                        par_q   <= par_bit;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        idx_q <= '0;
                        if (idx_q == IW'(DATA_BITS - 1)) begin
                            if (HAS_PARITY) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_q <= S_STOP;
                        idx_q   <= '0;
                        tx_q    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (idx_q == IW'(STOP_BITS - 1)) begin
                            success_q <= 1'b1;
                            idx_q     <= '0;
                            // Next start bit follows the last stop bit with no gap.
                            if (pop) begin
                                state_q <= S_START;
                                shift_q <= head;
                                par_q   <= par_bit;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.transmit_ready = !full;
    assign bus.overflow       = bus.tx_ctrl && full;
    assign bus.success        = success_q;
    assign bus.tx_dout        = tx_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.fifo_count     = count_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a frame table across four configurations
// plus hand-written overflow and mid-frame reset sequences.
module tb_uart_tx_fifo;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if2 ();
    uart_tx_fifo_if #(.DATA_BITS(5), .FIFO_DEPTH(4)) if3 ();

    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    uart_tx_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
        u3 (.clk(clk), .rst(rst), .bus(if3));

    logic [3:0] ctrl;
    logic [8:0] din [4];
    logic [3:0] dout_w, succ_w, busy_w, ready_w, ovf_w;
    logic [2:0] cnt_w [4];

    assign if0.tx_ctrl = ctrl[0];
    assign if1.tx_ctrl = ctrl[1];
    assign if2.tx_ctrl = ctrl[2];
    assign if3.tx_ctrl = ctrl[3];
    assign if0.data_send = din[0][7:0];
    assign if1.data_send = din[1][7:0];
    assign if2.data_send = din[2][7:0];
    assign if3.data_send = din[3][4:0];

    assign dout_w  = {if3.tx_dout, if2.tx_dout, if1.tx_dout, if0.tx_dout};
    assign succ_w  = {if3.success, if2.success, if1.success, if0.success};
    assign busy_w  = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign ready_w = {if3.transmit_ready, if2.transmit_ready, if1.transmit_ready, if0.transmit_ready};
    assign ovf_w   = {if3.overflow, if2.overflow, if1.overflow, if0.overflow};
    assign cnt_w[0] = if0.fifo_count;
    assign cnt_w[1] = if1.fifo_count;
    assign cnt_w[2] = if2.fifo_count;
    assign cnt_w[3] = if3.fifo_count;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // frame: transmitted bits written left to right (leftmost = start bit)
    typedef struct {
        int         inst;
        logic [8:0] data;
        int         cpb;
        int         nbits;
        logic [15:0] frame;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input vec_t v);
        int f;
        int spur;
        int i;
        i = v.inst;
        f = v.cpb * v.nbits;
        spur = 0;
        @(negedge clk);
        ctrl[i] = 1'b1;
        din[i]  = v.data;
        @(posedge clk);
        @(negedge clk);
        ctrl[i] = 1'b0;
        check($sformatf("count_after_write[%0d]", i), int'(cnt_w[i]), 1);
        check($sformatf("busy_after_write[%0d]", i), int'(busy_w[i]), 0);
        for (int k = 1; k <= f + 1; k++) begin
            @(negedge clk);
            if (k == 1)
                check($sformatf("count_after_pop[%0d]", i), int'(cnt_w[i]), 0);
            if (k <= f) begin
                check($sformatf("line[%0d] k=%0d", i, k), int'(dout_w[i]),
                      int'(v.frame[v.nbits - 1 - (k - 1) / v.cpb]));
                if (succ_w[i]) spur++;
            end else begin
                check($sformatf("success_time[%0d]", i), int'(succ_w[i]), 1);
            end
        end
        check($sformatf("early_success[%0d]", i), spur, 0);
        @(negedge clk);
        check($sformatf("success_width[%0d]", i), int'(succ_w[i]), 0);
        check($sformatf("idle_line[%0d]", i), int'(dout_w[i]), 1);
        check($sformatf("idle_busy[%0d]", i), int'(busy_w[i]), 0);
    endtask

    logic line_s [0:215];
    logic succ_s [0:215];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int spur;
        int bad;
        int byte_v;

        vecs[0] = '{0, 9'h0D3, 4, 10, 16'b0110010111};
        vecs[1] = '{0, 9'h000, 4, 10, 16'b0000000001};
        vecs[2] = '{0, 9'h0FF, 4, 10, 16'b0111111111};
        vecs[3] = '{1, 9'h05A, 4, 11, 16'b00101101001};
        vecs[4] = '{2, 9'h05A, 4, 11, 16'b00101101011};
        vecs[5] = '{1, 9'h001, 4, 11, 16'b01000000011};
        vecs[6] = '{3, 9'h016, 1, 8,  16'b00110111};
        vecs[7] = '{3, 9'h01F, 1, 8,  16'b01111111};
        vecs[8] = '{2, 9'h001, 4, 11, 16'b01000000001};

        ctrl = '0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_tx_dout", int'(dout_w[0]), 1);
        check("rst_success", int'(succ_w[0]), 0);
        check("rst_overflow", int'(ovf_w[0]), 0);
        check("rst_busy", int'(busy_w[0]), 0);
        check("rst_ready", int'(ready_w[0]), 1);
        check("rst_count", int'(cnt_w[0]), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 9; n++)
            run_vec(vecs[n]);

        // Overflow: six consecutive writes, fifth fills the FIFO, sixth dropped.
        @(negedge clk);
        ctrl[0] = 1'b1;
        din[0]  = 9'd1;
        @(posedge clk);
        for (int k = 0; k <= 215; k++) begin
            @(negedge clk);
            line_s[k] = dout_w[0];
            succ_s[k] = succ_w[0];
            if (k < 5) begin
                din[0] = 9'(k + 2);
            end else begin
                ctrl[0] = 1'b0;
            end
            #1;
            if (k == 3) check("ovf_ready_before_full", int'(ready_w[0]), 1);
            if (k == 4) begin
                check("ovf_ready_full", int'(ready_w[0]), 0);
                check("ovf_pulse", int'(ovf_w[0]), 1);
            end
            if (k == 5) begin
                check("ovf_count_after_drop", int'(cnt_w[0]), 4);
                check("ovf_pulse_width", int'(ovf_w[0]), 0);
            end
        end
        bad = 0;
        for (int k = 1; k <= 215; k++) begin
            if (succ_s[k] != ((k >= 41) && (k <= 201) && ((k - 41) % 40 == 0)))
                bad++;
        end
        check("ovf_success_times", bad, 0);
        for (int j = 0; j < 5; j++) begin
            byte_v = 0;
            for (int b = 0; b < 8; b++)
                byte_v = byte_v | (int'(line_s[40 * j + 6 + 4 * b]) << b);
            check($sformatf("ovf_frame_data[%0d]", j), byte_v, j + 1);
            check($sformatf("ovf_start_bit[%0d]", j), int'(line_s[40 * j + 2]), 0);
        end
        check("ovf_idle_line", int'(line_s[210]), 1);
        check("ovf_idle_busy", int'(busy_w[0]), 0);

        // Reset during data bit 3 of the first of two queued frames.
        @(negedge clk);
        ctrl[0] = 1'b1;
        din[0]  = 9'h0A5;
        @(posedge clk);
        @(negedge clk);
        din[0] = 9'h03C;
        @(posedge clk);
        spur = 0;
        bad  = 0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (succ_w[0]) spur++;
            if (k == 1) ctrl[0] = 1'b0;
            if (k == 17) begin
                check("mid_busy_before_rst", int'(busy_w[0]), 1);
                check("mid_count_before_rst", int'(cnt_w[0]), 1);
                rst = 1'b1;
            end
            if (k == 18) begin
                check("mid_rst_tx_dout", int'(dout_w[0]), 1);
                check("mid_rst_count", int'(cnt_w[0]), 0);
                check("mid_rst_busy", int'(busy_w[0]), 0);
                check("mid_rst_ready", int'(ready_w[0]), 1);
                rst = 1'b0;
            end
            if (k > 18 && (dout_w[0] != 1'b1 || busy_w[0] != 1'b0)) bad++;
        end
        check("mid_no_success", spur, 0);
        check("mid_no_more_frames", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter: the next-generation transmit path for the team's serial link. It adds configurable data width, bit period, parity mode and stop-bit count, plus a transmit FIFO that allows back-to-back frames. It accepts words on a single-cycle write strobe, serialises them LSB first on `tx_dout`, and pulses `success` once per completed frame. It sits between the host-side register/bus logic and the chip's TX pad.

## Interface
- DATA_BITS, 8, data bits per frame; legal 5..9
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal >= 1
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, transmit FIFO entries; power of 2, >= 2

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tx_ctrl  in  1  write strobe; one word pushed per cycle high
- data_send  in  DATA_BITS  word to push, sampled with tx_ctrl
- transmit_ready  out  1  FIFO not full (fifo_count < FIFO_DEPTH); combinational from count
- success  out  1  one-cycle pulse per completed frame
- tx_dout  out  1  serial line, idle high; registered
- busy  out  1  FSM not in IDLE
- overflow  out  1  one-cycle pulse when a write is dropped
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words currently buffered

## Operation
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Parity: even means data XOR parity equals 0 over the data bits plus the parity bit. Odd is the inverse. Parity is computed from the popped word.
- FIFO:
  - Push on tx_ctrl when not full. A push while full is dropped: FIFO unchanged, overflow=1 for that cycle.
  - The full check uses the current count. A pop in the same cycle does not free a slot for the push.
  - Simultaneous push and pop when not full is legal; the count is unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop and go to START.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY after DATA_BITS bits, or → STOP when PARITY=0.
  - PARITY → STOP after one bit.
  - STOP → (after STOP_BITS bits) START with a pop if the FIFO is non-empty, else IDLE.
- Counters: a bit-period counter (0..CLKS_PER_BIT-1) and a bit index; the shift register holds the popped word.
- Reset (any time, including mid-frame):
  - At the next edge: tx_dout=1, FSM=IDLE, FIFO emptied, fifo_count=0.
  - success=0, overflow=0, busy=0, transmit_ready=1.
  - A frame interrupted by reset never produces success.

## Timing
- Write at edge N into an empty FIFO with FSM in IDLE:
  - Pop at edge N+1; tx_dout=0 from edge N+1.
  - fifo_count is 1 for one cycle only, then returns to 0.
- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- success:
  - High for exactly the one cycle following the edge that ends the last stop bit, i.e. edge N+1+F.
  - In back-to-back operation it coincides with the first cycle of the next start bit.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- tx_dout changes only on bit-period boundaries. The line is 1 whenever busy=0.
- CLKS_PER_BIT=1 must work: one bit per cycle, same success and pop rules.

## Test plan
- Reset at defaults:
  - Stimulus: assert rst for 1 cycle with tx_ctrl=0.
  - Response: tx_dout=1, success=0, overflow=0, busy=0, transmit_ready=1, fifo_count=0.
- Single frame at defaults (F=40):
  - Stimulus: push 8'b11010011.
  - Response: tx_dout holds 0, 1,1,0,0,1,0,1,1, 1, each for 4 cycles. success pulses once, 41 cycles after the write edge. Line idles at 1 afterwards.
- Parity:
  - Stimulus: PARITY=1, push 8'h5A.
  - Response: parity bit 0. With PARITY=2 the parity bit is 1. F=44; success 45 cycles after the write.
- Overflow at defaults:
  - Stimulus: tx_ctrl high on 6 consecutive edges, data 1..6.
  - Response:
    - 5 words accepted; the 6th is dropped with a 1-cycle overflow pulse.
    - transmit_ready=0 for the cycle before the drop.
    - 5 frames sent back-to-back, with success pulses 40 cycles apart, in order 1..5.
- Reset mid-frame:
  - Stimulus: push 2 words, then assert rst during data bit 3.
  - Response: at the next edge tx_dout=1 and fifo_count=0. No success pulse; no further frames.
- Minimum-period configuration:
  - Stimulus: CLKS_PER_BIT=1, DATA_BITS=5, STOP_BITS=2, push 5'b10110.
  - Response: F=8; bits 0,0,1,1,0,1,1,1 on consecutive cycles; success exactly 9 cycles after the write.
